pickup_scheduler: RTL and testbench
===================================

Name: pickup_scheduler

Overview:
Sequences the life cycle of the single on-screen pickup in the tank game: respawn cooldown, position search, the active period, and claim or expiry. Takes candidate coordinates and type from external LFSRs and rejects positions that are off-screen or too close to a tank. While the pickup is active, it arbitrates between the two tanks and issues a one-cycle grant to the winner. Sits between the random generators, the tank position registers and the colour mapper/game-state logic.

Parameters:
RESPAWN_FRAMES, 300, frames of cooldown before a spawn attempt
LIFETIME_FRAMES, 600, frames an unclaimed pickup stays before expiring
PICKUP_SIZE, 8, pickup half-width in pixels
TANK_SIZE, 16, tank half-width in pixels
MIN_DIST, 48, minimum Manhattan distance from each tank centre at spawn
MAX_TRIES, 16, rejected samples before fallback position
SCREEN_W, 640 / SCREEN_H, 480, visible area

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync edge)
enable  in  1  game running; low freezes all timers and claims
force_spawn  in  1  skip the remaining cooldown
Tank1X, Tank1Y, Tank2X, Tank2Y  in  10 each  tank centres
rand_x, rand_y  in  10 each  LFSR candidates, new value every cycle
rand_type  in  2  LFSR candidate type
pickup_valid  out  1  pickup on screen
pickup_x, pickup_y  out  10 each  pickup centre
pickup_type  out  2  latched type
grant1, grant2  out  1  one-cycle claim pulse
grant_type  out  2  type carried with the grant
expired  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values:
  - State COOLDOWN; frame counter = RESPAWN_FRAMES.
  - All outputs 0; last_winner = tank2, so tank1 wins the first tie.
- COOLDOWN:
  - Counter decrements on each frame_tick while enable = 1.
  - Leave for SEARCH when the counter = 0 or on force_spawn while enable = 1; tries clears to 0.
- SEARCH (one candidate per cycle, only while enable = 1):
  - Candidate is valid if PICKUP_SIZE <= x < SCREEN_W-PICKUP_SIZE, PICKUP_SIZE <= y < SCREEN_H-PICKUP_SIZE, and |x-TnX|+|y-TnY| >= MIN_DIST for both tanks.
  - Differences are computed 11-bit signed, then absolute value; the sum is 12-bit.
  - Valid: latch x, y and rand_type; go to ACTIVE next cycle; lifetime counter = LIFETIME_FRAMES.
  - Invalid: tries++. The MAX_TRIES-th rejection accepts the fallback (SCREEN_W/2, SCREEN_H/2) with rand_type, unconditionally.
  - Worst-case spawn latency is MAX_TRIES cycles.
- ACTIVE:
  - pickup_valid = 1.
  - Overlap for tank n: |TnX-px| < TANK_SIZE+PICKUP_SIZE AND |TnY-py| < TANK_SIZE+PICKUP_SIZE, evaluated combinationally each cycle with enable = 1.
  - Exactly one tank overlaps: its grant is asserted the next cycle with grant_type = pickup_type.
  - Both overlap: the tank that is not last_winner is granted, and last_winner is updated.
  - In the grant cycle pickup_valid = 0 and the state is COOLDOWN with the counter reloaded. No second grant is possible for the same pickup.
  - The lifetime counter decrements per frame_tick. At 0 with no overlap that cycle: expired pulses, go to COOLDOWN. An overlap in the same cycle wins over expiry.
  - force_spawn is ignored in ACTIVE and SEARCH.
- enable = 0: state, counters and pickup position hold; no grants or expiry. pickup_valid keeps its value.
- Reset_n asserted mid-operation: immediate return to reset values; no grant or expired pulse is emitted.
- grant1, grant2 and expired are registered and never high together.

Decomposition:
- Package pickup_pkg holds:
  - enum pickup_state_t {COOLDOWN, SEARCH, ACTIVE}
  - enum pickup_kind_t {HEALTH, AMMO, SPEED, SHIELD} (2-bit)
  - screen constants
  - a function abs_diff(10-bit a, b) returning 10-bit
- Sub-module pickup_overlap: combinational AABB test (centre pair, half-size sum → hit), instantiated once per tank.
- The spawn-distance check stays inline.

Test Plan:
- Reset, then RESPAWN_FRAMES=4, enable=1, 4 frame_ticks, rand=(100,100,type 2), tanks at (500,400)/(600,50) → SEARCH, pickup_valid=1 at (100,100) type 2 the next cycle.
- Candidates (3,200), then (320,240) with Tank1 at (330,245), then (200,200) → two rejects; pickup at (200,200) on the third SEARCH cycle. With MAX_TRIES=4 and all candidates invalid → fallback (320,240).
- ACTIVE at (200,200); Tank2 moves to (220,210) → grant2=1 for one cycle, grant_type matches, pickup_valid=0, counter reloaded; Tank1 later at (200,200) gives no grant.
- Both tanks at (200,200) for two consecutive spawns → first grant1, then grant2 (alternation).
- LIFETIME_FRAMES=3 with no tank nearby → expired pulses after the 3rd frame_tick. Also: overlap in the expiry cycle → grant, no expired.
- Reset_n low during ACTIVE with overlap pending → all outputs 0 immediately, no pulse. Also: enable=0 during COOLDOWN with ticks → counter holds.

Source files
------------

// File: rtl/pickup_pkg.sv
// Shared types, screen geometry and the coordinate distance helper for the pickup scheduler.
// Pure declarations; no timing or backpressure.
package pickup_pkg;

    typedef enum logic [1:0] {COOLDOWN, SEARCH, ACTIVE} pickup_state_t;
    typedef enum logic [1:0] {HEALTH, AMMO, SPEED, SHIELD} pickup_kind_t;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Coordinates are unsigned, so widen by one bit before subtracting.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[COORD_W] ? COORD_W'(-d) : d[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/pickup_overlap.sv
// Axis-aligned box overlap test between two centres given the sum of their half-widths.
// Purely combinational, zero latency; no backpressure.
module pickup_overlap
    import pickup_pkg::*;
#(
    parameter int unsigned HALF_SUM = 24
) (
    input  logic [COORD_W-1:0] ax_i,
    input  logic [COORD_W-1:0] ay_i,
    input  logic [COORD_W-1:0] bx_i,
    input  logic [COORD_W-1:0] by_i,
    output logic               hit_o
);

    assign hit_o = (abs_diff(ax_i, bx_i) < COORD_W'(HALF_SUM)) &&
                   (abs_diff(ay_i, by_i) < COORD_W'(HALF_SUM));

endmodule

// File: rtl/pickup_scheduler.sv
// Pickup life cycle: cooldown, spawn search, active period, claim arbitration or expiry.
// Grants and expiry are registered one cycle after the deciding condition; enable low freezes everything.
module pickup_scheduler
    import pickup_pkg::*;
#(
    parameter int unsigned RESPAWN_FRAMES  = 300,
    parameter int unsigned LIFETIME_FRAMES = 600,
    parameter int unsigned PICKUP_SIZE     = 8,
    parameter int unsigned TANK_SIZE       = 16,
    parameter int unsigned MIN_DIST        = 48,
    parameter int unsigned MAX_TRIES       = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               enable,
    input  logic               force_spawn,
    input  logic [COORD_W-1:0] Tank1X,
    input  logic [COORD_W-1:0] Tank1Y,
    input  logic [COORD_W-1:0] Tank2X,
    input  logic [COORD_W-1:0] Tank2Y,
    input  logic [COORD_W-1:0] rand_x,
    input  logic [COORD_W-1:0] rand_y,
    input  logic [1:0]         rand_type,
    output logic               pickup_valid,
    output logic [COORD_W-1:0] pickup_x,
    output logic [COORD_W-1:0] pickup_y,
    output logic [1:0]         pickup_type,
    output logic               grant1,
    output logic               grant2,
    output logic [1:0]         grant_type,
    output logic               expired
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned TRY_W = $clog2(MAX_TRIES) + 1;

    pickup_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    pickup_kind_t       type_q, type_d, gtype_q, gtype_d;
    logic               last2_q, last2_d;   // 1: tank2 won the most recent tie
    logic               grant1_q, grant1_d, grant2_q, grant2_d, expired_q, expired_d;

    logic               hit1, hit2, win2, cand_ok;
    logic [11:0]        dist1, dist2;

    pickup_overlap #(.HALF_SUM(TANK_SIZE + PICKUP_SIZE)) u_ovl1 (
        .ax_i(Tank1X), .ay_i(Tank1Y), .bx_i(px_q), .by_i(py_q), .hit_o(hit1)
    );
    pickup_overlap #(.HALF_SUM(TANK_SIZE + PICKUP_SIZE)) u_ovl2 (
        .ax_i(Tank2X), .ay_i(Tank2Y), .bx_i(px_q), .by_i(py_q), .hit_o(hit2)
    );

    assign dist1 = {2'b00, abs_diff(rand_x, Tank1X)} + {2'b00, abs_diff(rand_y, Tank1Y)};
    assign dist2 = {2'b00, abs_diff(rand_x, Tank2X)} + {2'b00, abs_diff(rand_y, Tank2Y)};

    assign cand_ok = (rand_x >= COORD_W'(PICKUP_SIZE)) && (rand_x < COORD_W'(SCREEN_W - PICKUP_SIZE)) &&
                     (rand_y >= COORD_W'(PICKUP_SIZE)) && (rand_y < COORD_W'(SCREEN_H - PICKUP_SIZE)) &&
                     (dist1 >= 12'(MIN_DIST)) && (dist2 >= 12'(MIN_DIST));

    // On a tie the tank that did not win the previous tie takes it.
    assign win2 = hit2 && (!hit1 || !last2_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        px_d      = px_q;
        py_d      = py_q;
        type_d    = type_q;
        gtype_d   = gtype_q;
        last2_d   = last2_q;
        grant1_d  = 1'b0;
        grant2_d  = 1'b0;
        expired_d = 1'b0;
        if (enable) begin
            case (state_q)
                COOLDOWN: begin
                    if (cnt_q == '0 || force_spawn) begin
                        state_d = SEARCH;
                        tries_d = '0;
                    end else if (frame_tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SEARCH: begin
                    if (cand_ok || tries_q == TRY_W'(MAX_TRIES - 1)) begin
                        px_d    = cand_ok ? rand_x : COORD_W'(SCREEN_W / 2);
                        py_d    = cand_ok ? rand_y : COORD_W'(SCREEN_H / 2);
                        type_d  = pickup_kind_t'(rand_type);
                        cnt_d   = CNT_W'(LIFETIME_FRAMES);
                        state_d = ACTIVE;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                    end
                end
                ACTIVE: begin
                    if (hit1 || hit2) begin
                        grant1_d = !win2;
                        grant2_d = win2;
                        gtype_d  = type_q;
                        if (hit1 && hit2) last2_d = win2;
                        cnt_d    = CNT_W'(RESPAWN_FRAMES);
                        state_d  = COOLDOWN;
                    end else if (cnt_q == '0) begin
                        expired_d = 1'b1;
                        cnt_d     = CNT_W'(RESPAWN_FRAMES);
                        state_d   = COOLDOWN;
                    end else if (frame_tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = COOLDOWN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= COOLDOWN;
            cnt_q     <= CNT_W'(RESPAWN_FRAMES);
            tries_q   <= '0;
            px_q      <= '0;
            py_q      <= '0;
            type_q    <= HEALTH;
            gtype_q   <= HEALTH;
            last2_q   <= 1'b1;
            grant1_q  <= 1'b0;
            grant2_q  <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tries_q   <= tries_d;
            px_q      <= px_d;
            py_q      <= py_d;
            type_q    <= type_d;
            gtype_q   <= gtype_d;
            last2_q   <= last2_d;
            grant1_q  <= grant1_d;
            grant2_q  <= grant2_d;
            expired_q <= expired_d;
        end
    end

    assign pickup_valid = (state_q == ACTIVE);
    assign pickup_x     = px_q;
    assign pickup_y     = py_q;
    assign pickup_type  = type_q;
    assign grant1       = grant1_q;
    assign grant2       = grant2_q;
    assign grant_type   = gtype_q;
    assign expired      = expired_q;

endmodule

// File: tb/tb_pickup_scheduler.sv
// Directed bench for pickup_scheduler with short cooldown/lifetime/tries values.
module tb_pickup_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n, frame_tick, enable, force_spawn;
    logic [9:0] Tank1X, Tank1Y, Tank2X, Tank2Y, rand_x, rand_y;
    logic [1:0] rand_type;
    logic       pickup_valid, grant1, grant2, expired;
    logic [9:0] pickup_x, pickup_y;
    logic [1:0] pickup_type, grant_type;

    int checks = 0;
    int errors = 0;

    pickup_scheduler #(
        .RESPAWN_FRAMES(4), .LIFETIME_FRAMES(3), .PICKUP_SIZE(8),
        .TANK_SIZE(16), .MIN_DIST(48), .MAX_TRIES(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .enable(enable),
        .force_spawn(force_spawn),
        .Tank1X(Tank1X), .Tank1Y(Tank1Y), .Tank2X(Tank2X), .Tank2Y(Tank2Y),
        .rand_x(rand_x), .rand_y(rand_y), .rand_type(rand_type),
        .pickup_valid(pickup_valid), .pickup_x(pickup_x), .pickup_y(pickup_y),
        .pickup_type(pickup_type), .grant1(grant1), .grant2(grant2),
        .grant_type(grant_type), .expired(expired)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic set_tanks(input int x1, input int y1, input int x2, input int y2);
        Tank1X = 10'(x1); Tank1Y = 10'(y1); Tank2X = 10'(x2); Tank2Y = 10'(y2);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, pickup_valid, 0);
        chk({tag, "_x"}, pickup_x, 0);
        chk({tag, "_y"}, pickup_y, 0);
        chk({tag, "_type"}, pickup_type, 0);
        chk({tag, "_g1"}, grant1, 0);
        chk({tag, "_g2"}, grant2, 0);
        chk({tag, "_gtype"}, grant_type, 0);
        chk({tag, "_exp"}, expired, 0);
    endtask

    task automatic spawn(input int x, input int y, input int t);
        rand_x = 10'(x); rand_y = 10'(y); rand_type = 2'(t);
        force_spawn = 1'b1;
        step();
        force_spawn = 1'b0;
        step();
        chk("spawn_valid", pickup_valid, 1);
        chk("spawn_x", pickup_x, 32'(x));
        chk("spawn_y", pickup_y, 32'(y));
    endtask

    initial begin
        Reset_n = 1'b0; enable = 1'b0; force_spawn = 1'b0; frame_tick = 1'b0;
        set_tanks(500, 400, 600, 50);
        rand_x = 10'd100; rand_y = 10'd100; rand_type = 2'd2;
        step(); step();
        chk_idle("rst");
        Reset_n = 1'b1; enable = 1'b1;

        // First spawn through the cooldown counter
        repeat (4) tick();
        chk("cd_end_valid", pickup_valid, 0);
        step();
        chk("search_valid", pickup_valid, 0);
        step();
        chk("t1_valid", pickup_valid, 1);
        chk("t1_x", pickup_x, 100);
        chk("t1_y", pickup_y, 100);
        chk("t1_type", pickup_type, 2);

        force_spawn = 1'b1;
        step();
        force_spawn = 1'b0;
        chk("force_ign_valid", pickup_valid, 1);
        chk("force_ign_x", pickup_x, 100);

        // Expiry after three frames
        repeat (3) tick();
        chk("exp_pre_valid", pickup_valid, 1);
        chk("exp_pre", expired, 0);
        step();
        chk("exp_pulse", expired, 1);
        chk("exp_valid", pickup_valid, 0);
        chk("exp_g1", grant1, 0);
        step();
        chk("exp_end", expired, 0);

        // Disabled ticks must not count
        enable = 1'b0;
        repeat (6) tick();
        enable = 1'b1;
        repeat (3) tick();
        step(); step(); step();
        chk("en_hold_valid", pickup_valid, 0);
        tick();
        step();
        chk("en_search_valid", pickup_valid, 0);
        step();
        chk("en_resume_valid", pickup_valid, 1);

        // Single tank1 claim
        set_tanks(100, 100, 600, 50);
        step();
        chk("g1_single", grant1, 1);
        chk("g1_single_g2", grant2, 0);
        chk("g1_single_type", grant_type, 2);
        chk("g1_single_valid", pickup_valid, 0);
        set_tanks(330, 245, 600, 50);
        step();
        chk("g1_single_end", grant1, 0);

        // Two rejects then accept
        rand_x = 10'd3; rand_y = 10'd200; rand_type = 2'd1;
        force_spawn = 1'b1;
        step();
        force_spawn = 1'b0;
        step();
        chk("rej1_valid", pickup_valid, 0);
        rand_x = 10'd320; rand_y = 10'd240;
        step();
        chk("rej2_valid", pickup_valid, 0);
        rand_x = 10'd200; rand_y = 10'd200;
        step();
        chk("acc_valid", pickup_valid, 1);
        chk("acc_x", pickup_x, 200);
        chk("acc_y", pickup_y, 200);
        chk("acc_type", pickup_type, 1);

        // Tank2 claim
        set_tanks(330, 245, 220, 210);
        step();
        chk("g2_grant", grant2, 1);
        chk("g2_g1", grant1, 0);
        chk("g2_type", grant_type, 1);
        chk("g2_valid", pickup_valid, 0);
        chk("g2_exp", expired, 0);
        set_tanks(200, 200, 600, 50);
        step();
        chk("g2_end", grant2, 0);
        step();
        chk("no_regrant_g1", grant1, 0);
        chk("no_regrant_valid", pickup_valid, 0);

        // Reloaded cooldown, then fallback after four rejects
        rand_x = 10'd0; rand_y = 10'd100; rand_type = 2'd3;
        repeat (4) tick();
        step();
        chk("fb_search_valid", pickup_valid, 0);
        step(); step(); step();
        chk("fb_try3_valid", pickup_valid, 0);
        step();
        chk("fb_valid", pickup_valid, 1);
        chk("fb_x", pickup_x, 320);
        chk("fb_y", pickup_y, 240);
        chk("fb_type", pickup_type, 3);

        // Tie alternation
        set_tanks(320, 240, 320, 240);
        step();
        chk("tie1_g1", grant1, 1);
        chk("tie1_g2", grant2, 0);
        chk("tie1_type", grant_type, 3);
        set_tanks(50, 50, 600, 400);
        spawn(200, 200, 0);
        set_tanks(200, 200, 200, 200);
        step();
        chk("tie2_g2", grant2, 1);
        chk("tie2_g1", grant1, 0);
        chk("tie2_type", grant_type, 0);

        // Overlap in the expiry cycle beats expiry
        set_tanks(50, 50, 600, 400);
        spawn(200, 200, 1);
        repeat (3) tick();
        set_tanks(200, 200, 600, 400);
        step();
        chk("expovl_g1", grant1, 1);
        chk("expovl_exp", expired, 0);
        chk("expovl_valid", pickup_valid, 0);
        step();
        chk("expovl_exp_after", expired, 0);

        // Asynchronous reset with a claim pending
        set_tanks(50, 50, 600, 400);
        spawn(100, 100, 2);
        set_tanks(50, 50, 100, 100);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_idle("arst");
        step();
        chk_idle("arst_hold");
        Reset_n = 1'b1;
        step();
        chk("arst_rel_g2", grant2, 0);
        chk("arst_rel_valid", pickup_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
